// File: rtl/object_pattern_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : object_pattern_pkg
// Desc   : Pattern ROM entry layout, sequencer state encodings, entry unpacker.
// Rev    : 1.0
// ============================================================================
package object_pattern_pkg;

  localparam int ENTRY_W   = 67;
  localparam int TIMEOUT_W = 10;

  localparam int END_BIT   = 66;
  localparam int WAIT_LSB  = 58;
  localparam int WAIT_W    = 8;
  localparam int DIR_LSB   = 55;
  localparam int DIR_W     = 3;
  localparam int X_LSB     = 45;
  localparam int Y_LSB     = 35;
  localparam int W_LSB     = 25;
  localparam int H_LSB     = 15;
  localparam int COORD_W   = 10;
  localparam int SPEED_LSB = 10;
  localparam int SPEED_W   = 5;
  localparam int DTIME_LSB = 2;
  localparam int DTIME_W   = 8;
  localparam int DTRIG_LSB = 0;
  localparam int DTRIG_W   = 2;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_FETCH   = 3'd1;
  localparam logic [STATE_W-1:0] S_LOAD    = 3'd2;
  localparam logic [STATE_W-1:0] S_WAIT    = 3'd3;
  localparam logic [STATE_W-1:0] S_SEND    = 3'd4;
  localparam logic [STATE_W-1:0] S_RELEASE = 3'd5;
  localparam logic [STATE_W-1:0] S_ADVANCE = 3'd6;
  localparam logic [STATE_W-1:0] S_DONE    = 3'd7;

  typedef struct packed {
    logic [DIR_W-1:0]   dir;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [SPEED_W-1:0] speed;
    logic [DTIME_W-1:0] dtime;
    logic [DTRIG_W-1:0] dtrig;
  } obj_fields_t;

  function automatic obj_fields_t unpack_entry(input logic [ENTRY_W-1:0] e);
    obj_fields_t f;
    f.dir   = e[DIR_LSB   +: DIR_W];
    f.x     = e[X_LSB     +: COORD_W];
    f.y     = e[Y_LSB     +: COORD_W];
    f.w     = e[W_LSB     +: COORD_W];
    f.h     = e[H_LSB     +: COORD_W];
    f.speed = e[SPEED_LSB +: SPEED_W];
    f.dtime = e[DTIME_LSB +: DTIME_W];
    f.dtrig = e[DTRIG_LSB +: DTRIG_W];
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/object_pattern_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : object_pattern_sequencer_if
// Desc   : Object-load handshake between pattern sequencer (master) and runtime (slave).
// Rev    : 1.0
// ============================================================================
interface object_pattern_sequencer_if;
  logic [2:0] object_movement_direction;
  logic [9:0] object_pos_x;
  logic [9:0] object_pos_y;
  logic [9:0] object_w;
  logic [9:0] object_h;
  logic [4:0] object_speed;
  logic [7:0] object_destroy_time;
  logic [1:0] object_destroy_trigger;
  logic       sync_object_position;
  logic       update_object_position;

  modport master (
    output object_movement_direction, object_pos_x, object_pos_y, object_w, object_h,
           object_speed, object_destroy_time, object_destroy_trigger, sync_object_position,
    input  update_object_position
  );

  modport slave (
    input  object_movement_direction, object_pos_x, object_pos_y, object_w, object_h,
           object_speed, object_destroy_time, object_destroy_trigger, sync_object_position,
    output update_object_position
  );
endinterface
`default_nettype wire

// File: rtl/object_pattern_sequencer_wait_timer.sv
`default_nettype none
// ============================================================================
// Module : object_pattern_wait_timer
// Desc   : Loadable centi-second down-counter; holds at zero, freezes on pause.
// Rev    : 1.0
// ============================================================================
module object_pattern_wait_timer
  import object_pattern_pkg::*;
(
  input  wire              clk,
  input  wire              rst_n,
  input  wire              load_i,
  input  wire [WAIT_W-1:0] load_val_i,
  input  wire              tick_i,
  input  wire              pause_i,
  output logic             zero_o
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && !pause_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/object_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module : object_pattern_sequencer
// Desc   : Walks the pattern ROM and offers each object over the sync/update handshake.
//          Build option PATTERN_LOOP_EN: wrap to address 0 at end-of-pattern instead of DONE.
// Rev    : 1.0
// ============================================================================
module object_pattern_sequencer
  import object_pattern_pkg::*;
#(
  parameter int ADDR_W            = 6,
  parameter int HANDSHAKE_TIMEOUT = 1023
) (
  input  wire                        clk_calculation,
  input  wire                        reset_n,
  input  wire                        centi_tick,
  input  wire                        start,
  input  wire                        pause,
  output logic [ADDR_W-1:0]          rom_addr,
  input  wire  [ENTRY_W-1:0]         rom_data,
  object_pattern_sequencer_if.master obj,
  output logic                       busy,
  output logic                       done,
  output logic                       handshake_error
);

  localparam logic [TIMEOUT_W-1:0] c_TO_LIMIT = TIMEOUT_W'(HANDSHAKE_TIMEOUT - 1);

  logic [STATE_W-1:0]   state_q, state_d;
  logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
  logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
  logic                 seen_low_q, seen_low_d;
  logic                 end_q;
  obj_fields_t          fields_q;
  logic                 sync_q, sync_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic w_start_ok;
  logic w_wait_zero;
  logic w_to_hit;
  logic w_ack;
  logic w_hs_timeout;

  object_pattern_wait_timer u_wait_timer (
    .clk        (clk_calculation),
    .rst_n      (reset_n),
    .load_i     (state_q == S_LOAD),
    .load_val_i (rom_data[WAIT_LSB +: WAIT_W]),
    .tick_i     (centi_tick && (state_q == S_WAIT)),
    .pause_i    (pause),
    .zero_o     (w_wait_zero)
  );

  assign w_start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign w_to_hit   = (to_cnt_q >= c_TO_LIMIT);
  // A level-high update left over from the previous entry must drop once before it counts.
  assign w_ack      = obj.update_object_position && seen_low_q;

  always_ff @(posedge clk_calculation or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      to_cnt_q   <= '0;
      seen_low_q <= 1'b0;
      end_q      <= 1'b0;
      fields_q   <= '0;
      sync_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      to_cnt_q   <= to_cnt_d;
      seen_low_q <= seen_low_d;
      sync_q     <= sync_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      if (state_q == S_LOAD) begin
        fields_q <= unpack_entry(rom_data);
        end_q    <= rom_data[END_BIT];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    w_hs_timeout = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          rom_addr_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_WAIT;
      S_WAIT: begin
        if (w_wait_zero) state_d = S_SEND;
      end
      S_SEND: begin
        if (w_ack) begin
          state_d = S_RELEASE;
        end else if (w_to_hit) begin
          state_d      = S_RELEASE;
          w_hs_timeout = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!obj.update_object_position) begin
          state_d = S_ADVANCE;
        end else if (w_to_hit) begin
          state_d      = S_ADVANCE;
          w_hs_timeout = 1'b1;
        end
      end
      S_ADVANCE: begin
        if (end_q || (rom_addr_q == '1)) begin
`ifdef PATTERN_LOOP_EN
          rom_addr_d = '0;
          state_d    = S_FETCH;
`else
          state_d    = S_DONE;
`endif
        end else begin
          rom_addr_d = rom_addr_q + ADDR_W'(1);
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout count restarts on each state change, so each handshake edge gets a full budget.
    to_cnt_d = to_cnt_q;
    if (state_d != state_q) begin
      to_cnt_d = '0;
    end else if (((state_q == S_SEND) || (state_q == S_RELEASE)) && (to_cnt_q != '1)) begin
      to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
    end

    seen_low_d = seen_low_q;
    if (state_q != S_SEND) begin
      seen_low_d = 1'b0;
    end else if (!obj.update_object_position) begin
      seen_low_d = 1'b1;
    end
  end

  always_comb begin
    sync_d = (state_d != S_SEND);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    err_d  = err_q;
    if (w_start_ok) begin
      err_d = 1'b0;
    end else if (w_hs_timeout) begin
      err_d = 1'b1;
    end
  end

  assign rom_addr        = rom_addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign handshake_error = err_q;

  assign obj.sync_object_position      = sync_q;
  assign obj.object_movement_direction = fields_q.dir;
  assign obj.object_pos_x              = fields_q.x;
  assign obj.object_pos_y              = fields_q.y;
  assign obj.object_w                  = fields_q.w;
  assign obj.object_h                  = fields_q.h;
  assign obj.object_speed              = fields_q.speed;
  assign obj.object_destroy_time       = fields_q.dtime;
  assign obj.object_destroy_trigger    = fields_q.dtrig;

endmodule
`default_nettype wire
